// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I memory-access stage with single-outstanding req/ack data bus
module memory_stage #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                   me_clk,
    input  logic                   me_rst,
    input  logic                   me_i_ce,
    input  logic [6:0]             me_i_opcode,
    input  logic [FUNCT_WIDTH-1:0] me_i_funct3,
    input  logic [DWIDTH-1:0]      me_i_alu_value,
    input  logic [DWIDTH-1:0]      me_i_data_rs2,
    input  logic [AWIDTH-1:0]      me_i_addr_rd,
    input  logic                   me_i_we_reg,
    input  logic                   me_i_stall,
    input  logic                   me_i_flush,
    output logic                   me_o_stall,
    output logic                   me_o_stb,
    output logic                   me_o_we,
    output logic [DWIDTH-1:0]      me_o_addr,
    output logic [3:0]             me_o_sel,
    output logic [DWIDTH-1:0]      me_o_wdata,
    input  logic                   me_i_ack,
    input  logic [DWIDTH-1:0]      me_i_rdata,
    output logic                   me_o_ce,
    output logic [AWIDTH-1:0]      me_o_addr_rd,
    output logic [DWIDTH-1:0]      me_o_data_rd,
    output logic                   me_o_we_reg,
    output logic                   me_o_misaligned
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t                 state;
    logic [FUNCT_WIDTH-1:0] q_funct3;
    logic [1:0]             q_off;
    logic                   q_store;
    logic                   q_we_reg;
    logic                   q_flushed;
    logic [AWIDTH-1:0]      q_rd;
    logic [DWIDTH-1:0]      hold_data;
    logic                   hold_we;

    logic                   is_load;
    logic                   is_store;
    logic                   is_mem;
    logic                   misaligned;
    logic                   rd_nz;
    logic [3:0]             st_sel;
    logic [DWIDTH-1:0]      st_wdata;
    logic [DWIDTH-1:0]      shifted;
    logic [DWIDTH-1:0]      load_data;
    logic                   sgn_b;
    logic                   sgn_h;
    logic [DWIDTH-1:0]      wb_data;
    logic                   wb_we;

    assign me_o_stall = (state != S_IDLE) | me_i_stall;
    assign is_load    = (me_i_opcode == OP_LOAD);
    assign is_store   = (me_i_opcode == OP_STORE);
    assign is_mem     = is_load | is_store;
    assign rd_nz      = |me_i_addr_rd;

    // Halfwords need bit 0 clear, words need both low address bits clear
    assign misaligned = ((me_i_funct3[1:0] == 2'b01) & me_i_alu_value[0]) |
                        ((me_i_funct3[1:0] == 2'b10) & (me_i_alu_value[1:0] != 2'b00));

    // Store byte-lane steering: data is replicated so any selected lane carries it
    always_comb begin
        st_sel   = 4'b1111;
        st_wdata = me_i_data_rs2;
        case (me_i_funct3[1:0])
            2'b00: begin
                st_sel   = 4'b0001 << me_i_alu_value[1:0];
                st_wdata = {4{me_i_data_rs2[7:0]}};
            end
            2'b01: begin
                st_sel   = me_i_alu_value[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{me_i_data_rs2[15:0]}};
            end
            default: begin
                st_sel   = 4'b1111;
                st_wdata = me_i_data_rs2;
            end
        endcase
    end

    // Load alignment and sign/zero extension of the returned word
    always_comb begin
        shifted   = me_i_rdata >> {q_off, 3'b000};
        sgn_b     = ~q_funct3[2] & shifted[7];
        sgn_h     = ~q_funct3[2] & shifted[15];
        load_data = shifted;
        case (q_funct3[1:0])
            2'b00:   load_data = {{(DWIDTH-8){sgn_b}}, shifted[7:0]};
            2'b01:   load_data = {{(DWIDTH-16){sgn_h}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
        wb_data = q_store ? '0 : load_data;
        wb_we   = ~q_store & q_we_reg;
    end

    // Stage FSM: accept, issue bus cycle, wait for ack, optionally buffer under downstream stall
    always_ff @(posedge me_clk or negedge me_rst) begin
        if (!me_rst) begin
            state           <= S_IDLE;
            q_funct3        <= '0;
            q_off           <= 2'b00;
            q_store         <= 1'b0;
            q_we_reg        <= 1'b0;
            q_flushed       <= 1'b0;
            q_rd            <= '0;
            hold_data       <= '0;
            hold_we         <= 1'b0;
            me_o_stb        <= 1'b0;
            me_o_we         <= 1'b0;
            me_o_addr       <= '0;
            me_o_sel        <= 4'b0000;
            me_o_wdata      <= '0;
            me_o_ce         <= 1'b0;
            me_o_addr_rd    <= '0;
            me_o_data_rd    <= '0;
            me_o_we_reg     <= 1'b0;
            me_o_misaligned <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (me_i_flush) begin
                        me_o_ce         <= 1'b0;
                        me_o_misaligned <= 1'b0;
                    end else if (!me_i_stall) begin
                        me_o_ce         <= 1'b0;
                        me_o_misaligned <= 1'b0;
                        if (me_i_ce) begin
                            if (is_mem && !misaligned) begin
                                state      <= S_WAIT;
                                me_o_stb   <= 1'b1;
                                me_o_we    <= is_store;
                                me_o_addr  <= {me_i_alu_value[DWIDTH-1:2], 2'b00};
                                me_o_sel   <= is_store ? st_sel : 4'b1111;
                                me_o_wdata <= is_store ? st_wdata : '0;
                                q_funct3   <= me_i_funct3;
                                q_off      <= me_i_alu_value[1:0];
                                q_store    <= is_store;
                                q_we_reg   <= me_i_we_reg & rd_nz;
                                q_flushed  <= 1'b0;
                                q_rd       <= me_i_addr_rd;
                            end else if (is_mem) begin
                                me_o_ce         <= 1'b1;
                                me_o_misaligned <= 1'b1;
                                me_o_we_reg     <= 1'b0;
                                me_o_addr_rd    <= me_i_addr_rd;
                                me_o_data_rd    <= me_i_alu_value;
                            end else begin
                                me_o_ce      <= 1'b1;
                                me_o_we_reg  <= me_i_we_reg & rd_nz;
                                me_o_addr_rd <= me_i_addr_rd;
                                me_o_data_rd <= me_i_alu_value;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (me_i_flush) begin
                        q_flushed <= 1'b1;
                    end
                    if (me_i_ack) begin
                        me_o_stb <= 1'b0;
                        if (q_flushed || me_i_flush) begin
                            state <= S_IDLE;
                        end else if (me_i_stall) begin
                            state     <= S_HOLD;
                            hold_data <= wb_data;
                            hold_we   <= wb_we;
                        end else begin
                            state           <= S_IDLE;
                            me_o_ce         <= 1'b1;
                            me_o_misaligned <= 1'b0;
                            me_o_data_rd    <= wb_data;
                            me_o_addr_rd    <= q_rd;
                            me_o_we_reg     <= wb_we;
                        end
                    end
                end
                S_HOLD: begin
                    if (me_i_flush) begin
                        state <= S_IDLE;
                    end else if (!me_i_stall) begin
                        state           <= S_IDLE;
                        me_o_ce         <= 1'b1;
                        me_o_misaligned <= 1'b0;
                        me_o_data_rd    <= hold_data;
                        me_o_addr_rd    <= q_rd;
                        me_o_we_reg     <= hold_we;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        me_clk = 1'b0;
    logic        me_rst;
    logic        me_i_ce;
    logic [6:0]  me_i_opcode;
    logic [2:0]  me_i_funct3;
    logic [31:0] me_i_alu_value;
    logic [31:0] me_i_data_rs2;
    logic [4:0]  me_i_addr_rd;
    logic        me_i_we_reg;
    logic        me_i_stall;
    logic        me_i_flush;
    logic        me_o_stall;
    logic        me_o_stb;
    logic        me_o_we;
    logic [31:0] me_o_addr;
    logic [3:0]  me_o_sel;
    logic [31:0] me_o_wdata;
    logic        me_i_ack;
    logic [31:0] me_i_rdata;
    logic        me_o_ce;
    logic [4:0]  me_o_addr_rd;
    logic [31:0] me_o_data_rd;
    logic        me_o_we_reg;
    logic        me_o_misaligned;

    int checks = 0;
    int errs   = 0;

    memory_stage #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3)) dut (
        .me_clk(me_clk), .me_rst(me_rst), .me_i_ce(me_i_ce), .me_i_opcode(me_i_opcode),
        .me_i_funct3(me_i_funct3), .me_i_alu_value(me_i_alu_value), .me_i_data_rs2(me_i_data_rs2),
        .me_i_addr_rd(me_i_addr_rd), .me_i_we_reg(me_i_we_reg), .me_i_stall(me_i_stall),
        .me_i_flush(me_i_flush), .me_o_stall(me_o_stall), .me_o_stb(me_o_stb), .me_o_we(me_o_we),
        .me_o_addr(me_o_addr), .me_o_sel(me_o_sel), .me_o_wdata(me_o_wdata), .me_i_ack(me_i_ack),
        .me_i_rdata(me_i_rdata), .me_o_ce(me_o_ce), .me_o_addr_rd(me_o_addr_rd),
        .me_o_data_rd(me_o_data_rd), .me_o_we_reg(me_o_we_reg), .me_o_misaligned(me_o_misaligned)
    );

    always #5 me_clk = ~me_clk;

    task automatic tick();
        @(posedge me_clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic we);
        me_i_ce = 1'b1; me_i_opcode = op; me_i_funct3 = f3; me_i_alu_value = alu;
        me_i_data_rs2 = rs2; me_i_addr_rd = rd; me_i_we_reg = we;
    endtask

    task automatic idle_inputs();
        me_i_ce = 1'b0; me_i_opcode = 7'd0; me_i_funct3 = 3'd0; me_i_alu_value = 32'd0;
        me_i_data_rs2 = 32'd0; me_i_addr_rd = 5'd0; me_i_we_reg = 1'b0;
        me_i_stall = 1'b0; me_i_flush = 1'b0; me_i_ack = 1'b0; me_i_rdata = 32'd0;
    endtask

    // Accept a memory op, wait `gap` cycles with no ack, then ack with rdata
    task automatic bus_run(input int gap, input logic [31:0] rdata);
        tick();
        me_i_ce = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        me_i_ack = 1'b1; me_i_rdata = rdata;
        tick();
        me_i_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        me_rst = 1'b0;
        tick(); tick();
        checks++; if (me_o_ce !== 1'b0) begin errs++; $display("FAIL reset_ce got %0h want 0", me_o_ce); end
        checks++; if (me_o_stb !== 1'b0) begin errs++; $display("FAIL reset_stb got %0h want 0", me_o_stb); end
        checks++; if (me_o_data_rd !== 32'h0) begin errs++; $display("FAIL reset_data got %08h want 00000000", me_o_data_rd); end
        checks++; if (me_o_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %0h want 0", me_o_stall); end
        me_rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive(OP_ALU, 3'b000, 32'h0000002A, 32'h0, 5'd5, 1'b1);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_ce !== 1'b1) begin errs++; $display("FAIL alu_ce got %0h want 1", me_o_ce); end
        checks++; if (me_o_data_rd !== 32'h2A) begin errs++; $display("FAIL alu_data got %08h want 0000002a", me_o_data_rd); end
        checks++; if (me_o_we_reg !== 1'b1) begin errs++; $display("FAIL alu_we got %0h want 1", me_o_we_reg); end
        checks++; if (me_o_addr_rd !== 5'd5) begin errs++; $display("FAIL alu_rd got %0d want 5", me_o_addr_rd); end
        checks++; if (me_o_stb !== 1'b0) begin errs++; $display("FAIL alu_stb got %0h want 0", me_o_stb); end
        tick();
        checks++; if (me_o_ce !== 1'b0) begin errs++; $display("FAIL alu_ce_pulse got %0h want 0", me_o_ce); end
        drive(OP_ALU, 3'b000, 32'h12345678, 32'h0, 5'd0, 1'b1);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_we_reg !== 1'b0) begin errs++; $display("FAIL alu_x0_we got %0h want 0", me_o_we_reg); end
        tick();
    endtask

    task automatic test_lb();
        int stall_cycles;
        stall_cycles = 0;
        drive(OP_LOAD, 3'b000, 32'h00000103, 32'h0, 5'd7, 1'b1);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_stb !== 1'b1) begin errs++; $display("FAIL lb_stb got %0h want 1", me_o_stb); end
        checks++; if (me_o_addr !== 32'h100) begin errs++; $display("FAIL lb_addr got %08h want 00000100", me_o_addr); end
        checks++; if (me_o_we !== 1'b0) begin errs++; $display("FAIL lb_we got %0h want 0", me_o_we); end
        for (int i = 0; i < 3; i++) begin
            if (me_o_stall === 1'b1) stall_cycles++;
            if (i == 2) begin me_i_ack = 1'b1; me_i_rdata = 32'h80FF0000; end
            tick();
        end
        me_i_ack = 1'b0;
        if (me_o_stall === 1'b1) stall_cycles++;
        checks++; if (stall_cycles !== 3) begin errs++; $display("FAIL lb_stall_cycles got %0d want 3", stall_cycles); end
        checks++; if (me_o_stb !== 1'b0) begin errs++; $display("FAIL lb_stb_drop got %0h want 0", me_o_stb); end
        checks++; if (me_o_ce !== 1'b1) begin errs++; $display("FAIL lb_ce got %0h want 1", me_o_ce); end
        checks++; if (me_o_data_rd !== 32'hFFFFFF80) begin errs++; $display("FAIL lb_data got %08h want ffffff80", me_o_data_rd); end
        checks++; if (me_o_we_reg !== 1'b1) begin errs++; $display("FAIL lb_we_reg got %0h want 1", me_o_we_reg); end
        checks++; if (me_o_addr_rd !== 5'd7) begin errs++; $display("FAIL lb_rd got %0d want 7", me_o_addr_rd); end
        tick();
        checks++; if (me_o_ce !== 1'b0) begin errs++; $display("FAIL lb_ce_pulse got %0h want 0", me_o_ce); end
    endtask

    task automatic test_load_ext();
        drive(OP_LOAD, 3'b101, 32'h00000102, 32'h0, 5'd3, 1'b1);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_addr !== 32'h100) begin errs++; $display("FAIL lhu_addr got %08h want 00000100", me_o_addr); end
        checks++; if (me_o_sel !== 4'b1111) begin errs++; $display("FAIL lhu_sel got %04b want 1111", me_o_sel); end
        me_i_ack = 1'b1; me_i_rdata = 32'hBEEF1234;
        tick();
        me_i_ack = 1'b0;
        checks++; if (me_o_data_rd !== 32'h0000BEEF) begin errs++; $display("FAIL lhu_data got %08h want 0000beef", me_o_data_rd); end
        drive(OP_LOAD, 3'b001, 32'h00000102, 32'h0, 5'd3, 1'b1);
        bus_run(0, 32'hBEEF1234);
        checks++; if (me_o_data_rd !== 32'hFFFFBEEF) begin errs++; $display("FAIL lh_data got %08h want ffffbeef", me_o_data_rd); end
        drive(OP_LOAD, 3'b100, 32'h00000101, 32'h0, 5'd3, 1'b1);
        bus_run(1, 32'hBEEF1234);
        checks++; if (me_o_data_rd !== 32'h00000012) begin errs++; $display("FAIL lbu_data got %08h want 00000012", me_o_data_rd); end
        drive(OP_LOAD, 3'b010, 32'h00000204, 32'h0, 5'd0, 1'b1);
        bus_run(0, 32'hCAFEF00D);
        checks++; if (me_o_data_rd !== 32'hCAFEF00D) begin errs++; $display("FAIL lw_data got %08h want cafef00d", me_o_data_rd); end
        checks++; if (me_o_we_reg !== 1'b0) begin errs++; $display("FAIL lw_x0_we got %0h want 0", me_o_we_reg); end
        tick();
    endtask

    task automatic test_store();
        drive(OP_STORE, 3'b000, 32'h00000021, 32'h123456AB, 5'd9, 1'b0);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_sel !== 4'b0010) begin errs++; $display("FAIL sb_sel got %04b want 0010", me_o_sel); end
        checks++; if (me_o_wdata !== 32'hABABABAB) begin errs++; $display("FAIL sb_wdata got %08h want abababab", me_o_wdata); end
        checks++; if (me_o_we !== 1'b1) begin errs++; $display("FAIL sb_we got %0h want 1", me_o_we); end
        checks++; if (me_o_addr !== 32'h20) begin errs++; $display("FAIL sb_addr got %08h want 00000020", me_o_addr); end
        me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0;
        checks++; if (me_o_ce !== 1'b1) begin errs++; $display("FAIL sb_ce got %0h want 1", me_o_ce); end
        checks++; if (me_o_we_reg !== 1'b0) begin errs++; $display("FAIL sb_we_reg got %0h want 0", me_o_we_reg); end
        drive(OP_STORE, 3'b001, 32'h00000022, 32'h1234ABCD, 5'd9, 1'b1);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_sel !== 4'b1100) begin errs++; $display("FAIL sh_sel got %04b want 1100", me_o_sel); end
        checks++; if (me_o_wdata !== 32'hABCDABCD) begin errs++; $display("FAIL sh_wdata got %08h want abcdabcd", me_o_wdata); end
        me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0;
        checks++; if (me_o_we_reg !== 1'b0) begin errs++; $display("FAIL sh_we_reg got %0h want 0", me_o_we_reg); end
        drive(OP_STORE, 3'b010, 32'h00000040, 32'hDEADBEEF, 5'd9, 1'b0);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_sel !== 4'b1111) begin errs++; $display("FAIL sw_sel got %04b want 1111", me_o_sel); end
        checks++; if (me_o_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wdata got %08h want deadbeef", me_o_wdata); end
        me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        drive(OP_LOAD, 3'b010, 32'h00000102, 32'h0, 5'd4, 1'b1);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_stb !== 1'b0) begin errs++; $display("FAIL mis_lw_stb got %0h want 0", me_o_stb); end
        checks++; if (me_o_ce !== 1'b1) begin errs++; $display("FAIL mis_lw_ce got %0h want 1", me_o_ce); end
        checks++; if (me_o_misaligned !== 1'b1) begin errs++; $display("FAIL mis_lw_flag got %0h want 1", me_o_misaligned); end
        checks++; if (me_o_we_reg !== 1'b0) begin errs++; $display("FAIL mis_lw_we got %0h want 0", me_o_we_reg); end
        tick();
        checks++; if (me_o_misaligned !== 1'b0) begin errs++; $display("FAIL mis_lw_pulse got %0h want 0", me_o_misaligned); end
        drive(OP_STORE, 3'b001, 32'h00000023, 32'h0, 5'd0, 1'b0);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_misaligned !== 1'b1 || me_o_stb !== 1'b0) begin errs++; $display("FAIL mis_sh got flag=%0h stb=%0h want 1 0", me_o_misaligned, me_o_stb); end
        tick();
    endtask

    task automatic test_flush();
        drive(OP_LOAD, 3'b010, 32'h00000200, 32'h0, 5'd6, 1'b1);
        tick();
        me_i_ce = 1'b0;
        me_i_flush = 1'b1;
        tick();
        me_i_flush = 1'b0;
        checks++; if (me_o_stb !== 1'b1) begin errs++; $display("FAIL flush_wait_stb got %0h want 1", me_o_stb); end
        me_i_ack = 1'b1; me_i_rdata = 32'h11111111;
        tick();
        me_i_ack = 1'b0;
        checks++; if (me_o_ce !== 1'b0) begin errs++; $display("FAIL flush_wait_ce got %0h want 0", me_o_ce); end
        checks++; if (me_o_stall !== 1'b0 || me_o_stb !== 1'b0) begin errs++; $display("FAIL flush_wait_idle got stall=%0h stb=%0h want 0 0", me_o_stall, me_o_stb); end
        drive(OP_LOAD, 3'b010, 32'h00000200, 32'h0, 5'd6, 1'b1);
        me_i_flush = 1'b1;
        tick();
        me_i_ce = 1'b0; me_i_flush = 1'b0;
        checks++; if (me_o_stb !== 1'b0 || me_o_ce !== 1'b0) begin errs++; $display("FAIL flush_accept got stb=%0h ce=%0h want 0 0", me_o_stb, me_o_ce); end
        me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0;
        checks++; if (me_o_ce !== 1'b0) begin errs++; $display("FAIL ack_idle_ce got %0h want 0", me_o_ce); end
    endtask

    task automatic test_stall();
        me_i_stall = 1'b1;
        drive(OP_ALU, 3'b000, 32'h55, 32'h0, 5'd2, 1'b1);
        tick();
        checks++; if (me_o_ce !== 1'b0) begin errs++; $display("FAIL stall_idle_ce got %0h want 0", me_o_ce); end
        checks++; if (me_o_stall !== 1'b1) begin errs++; $display("FAIL stall_idle_ostall got %0h want 1", me_o_stall); end
        me_i_stall = 1'b0;
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_ce !== 1'b1 || me_o_data_rd !== 32'h55) begin errs++; $display("FAIL stall_release got ce=%0h data=%08h want 1 00000055", me_o_ce, me_o_data_rd); end
        drive(OP_LOAD, 3'b100, 32'h00000101, 32'h0, 5'd8, 1'b1);
        tick();
        me_i_ce = 1'b0;
        me_i_ack = 1'b1; me_i_rdata = 32'hBEEF1234; me_i_stall = 1'b1;
        tick();
        me_i_ack = 1'b0;
        checks++; if (me_o_stb !== 1'b0 || me_o_ce !== 1'b0) begin errs++; $display("FAIL hold_enter got stb=%0h ce=%0h want 0 0", me_o_stb, me_o_ce); end
        tick();
        checks++; if (me_o_ce !== 1'b0) begin errs++; $display("FAIL hold_wait_ce got %0h want 0", me_o_ce); end
        me_i_stall = 1'b0;
        checks++; if (me_o_stall !== 1'b1) begin errs++; $display("FAIL hold_stall got %0h want 1", me_o_stall); end
        tick();
        checks++; if (me_o_ce !== 1'b1 || me_o_data_rd !== 32'h12) begin errs++; $display("FAIL hold_release got ce=%0h data=%08h want 1 00000012", me_o_ce, me_o_data_rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(OP_ALU, 3'b000, 32'hA1, 32'h0, 5'd1, 1'b1);
        tick();
        drive(OP_ALU, 3'b000, 32'hB2, 32'h0, 5'd2, 1'b1);
        checks++; if (me_o_ce !== 1'b1 || me_o_data_rd !== 32'hA1) begin errs++; $display("FAIL b2b_first got ce=%0h data=%08h want 1 000000a1", me_o_ce, me_o_data_rd); end
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_ce !== 1'b1 || me_o_data_rd !== 32'hB2 || me_o_addr_rd !== 5'd2) begin errs++; $display("FAIL b2b_second got ce=%0h data=%08h rd=%0d want 1 000000b2 2", me_o_ce, me_o_data_rd, me_o_addr_rd); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive(OP_LOAD, 3'b010, 32'h00000300, 32'h0, 5'd3, 1'b1);
        tick();
        me_i_ce = 1'b0;
        checks++; if (me_o_stb !== 1'b1) begin errs++; $display("FAIL rstw_pre_stb got %0h want 1", me_o_stb); end
        #2 me_rst = 1'b0;
        #1;
        checks++; if (me_o_stb !== 1'b0) begin errs++; $display("FAIL rstw_stb got %0h want 0", me_o_stb); end
        checks++; if (me_o_stall !== 1'b0) begin errs++; $display("FAIL rstw_state got stall=%0h want 0", me_o_stall); end
        tick();
        me_rst = 1'b1;
        tick();
        checks++; if (me_o_stb !== 1'b0 || me_o_ce !== 1'b0) begin errs++; $display("FAIL rstw_after got stb=%0h ce=%0h want 0 0", me_o_stb, me_o_ce); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_load_ext();
        test_store();
        test_misaligned();
        test_flush();
        test_stall();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
